// File: rtl/cpu_pkg.sv
// Shared types and default widths for the CPU memory path.
package cpu_pkg;

   localparam int CPU_WORD_W = 32;
   localparam int CPU_ADDR_W = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2,
      HOLD = 2'd3
   } mem_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the control unit (master) and mem_responder (slave).
interface mem_responder_if #(
   parameter int ADDR_W = 9,
   parameter int WORD_W = 32
) ();

   logic              read;
   logic              wren;
   logic [ADDR_W-1:0] addr;
   logic [WORD_W-1:0] wdata;
   logic [WORD_W-1:0] rdata;
   logic              done;
   logic              busy;
   logic              err;

   modport master (
      output read, wren, addr, wdata,
      input  rdata, done, busy, err
   );

   modport slave (
      input  read, wren, addr, wdata,
      output rdata, done, busy, err
   );

endinterface

// File: rtl/mem_array.sv
// Synchronous single-port word RAM; contents are not reset, the read register is.
module mem_array #(
   parameter int ADDR_W = 9,
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] q
);

   logic [WORD_W-1:0] r_mem [2**ADDR_W];
   logic [WORD_W-1:0] r_q;

   // storage write; left out of reset so the array maps onto plain RAM
   always_ff @(posedge clk) begin
      if (we) r_mem[addr] <= wdata;
   end

   // read register only loads on a read so it holds across writes and idle time
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  r_q <= '0;
      else if (re) r_q <= r_mem[addr];
   end

   assign q = r_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts a read/write request, inserts wait states, pulses done.
//
//   state | meaning
//   IDLE  | no access in flight, waiting for read|wren
//   WAIT  | request latched, counting down wait states
//   DONE  | access committed this edge; done (and err) high for one cycle
//   HOLD  | access finished, waiting for the requester to drop its level
module mem_responder
   import cpu_pkg::*;
#(
   parameter int ADDR_W      = CPU_ADDR_W,
   parameter int WORD_W      = CPU_WORD_W,
   parameter int WAIT_CYCLES = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   mem_responder_if.slave bus
);

   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   mem_state_t        r_state;
   mem_state_t        w_next;
   logic [3:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [WORD_W-1:0] r_wdata;
   logic              r_op_wr;
   logic              r_conf;

   logic              w_req;
   logic              w_idle;
   logic              w_enter_done;
   logic              w_op_wr;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [WORD_W-1:0] w_mem_wdata;
   logic              w_done;
   logic              w_err;
   logic              w_busy;

   assign w_req  = bus.read | bus.wren;
   assign w_idle = (r_state == IDLE);

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: if (w_req) w_next = (WAIT_CYCLES == 0) ? DONE : WAIT;
         WAIT: if (r_cnt == 4'd0) w_next = DONE;
         DONE: w_next = w_req ? HOLD : IDLE;
         HOLD: if (!w_req) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // outputs are pure functions of the registered state
   always_comb begin
      w_done = (r_state == DONE);
      w_err  = w_done & r_conf;
      w_busy = (r_state != IDLE);
   end

   // request latches and wait counter; later bus changes are ignored until IDLE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= 4'd0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_op_wr <= 1'b0;
         r_conf  <= 1'b0;
      end else if (w_idle && w_req) begin
         r_cnt   <= CNT_INIT;
         r_addr  <= bus.addr;
         r_wdata <= bus.wdata;
         r_op_wr <= bus.wren;
         r_conf  <= bus.read & bus.wren;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // with zero wait states the array is hit on the acceptance edge, so use the live bus
   assign w_enter_done = (w_next == DONE) && (r_state != DONE);
   assign w_op_wr      = w_idle ? bus.wren  : r_op_wr;
   assign w_mem_addr   = w_idle ? bus.addr  : r_addr;
   assign w_mem_wdata  = w_idle ? bus.wdata : r_wdata;

   mem_array #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W)
   ) u_mem_array (
      .clk   (clk),
      .rst_n (reset_n),
      .we    (w_enter_done & w_op_wr),
      .re    (w_enter_done & ~w_op_wr),
      .addr  (w_mem_addr),
      .wdata (w_mem_wdata),
      .q     (bus.rdata)
   );

   assign bus.done = w_done;
   assign bus.err  = w_err;
   assign bus.busy = w_busy;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (WAIT_CYCLES = 2 main instance, 0 for latency corner).
module tb_mem_responder;
   import cpu_pkg::*;

   typedef struct {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   mem_responder_if #(.ADDR_W(9), .WORD_W(32)) bus2 ();
   mem_responder_if #(.ADDR_W(9), .WORD_W(32)) bus0 ();

   mem_responder #(.ADDR_W(9), .WORD_W(32), .WAIT_CYCLES(2)) dut2 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus2.slave)
   );

   mem_responder #(.ADDR_W(9), .WORD_W(32), .WAIT_CYCLES(0)) dut0 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus0.slave)
   );

   int          n_total = 0;
   int          n_bad   = 0;
   int          n_done  = 0;
   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] model[int];
   logic [31:0] last_rd = 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // every done pulse retires the oldest expected result
   always @(negedge clk) begin
      if (reset_n === 1'b1 && bus2.done === 1'b1) begin
         n_done++;
         if (sb.size() == 0) begin
            chk("spurious_done", 32'(sb.size()), 32'd1);
         end else begin
            mon_e = sb.pop_front();
            chk("rdata", bus2.rdata, mon_e.rd);
            chk("err", 32'(bus2.err), 32'(mon_e.err));
         end
      end
   end

   // one access on the WAIT_CYCLES=2 instance; request held for 'hold' cycles
   task automatic issue(input logic rd, input logic wr, input logic [8:0] a,
                        input logic [31:0] d, input int hold, input logic chg);
      exp_t e;
      int   lat = 0;
      int   d0  = n_done;
      if (wr) begin
         model[int'(a)] = d;
      end else begin
         last_rd = model.exists(int'(a)) ? model[int'(a)] : 32'h0;
      end
      e.rd  = last_rd;
      e.err = rd & wr;
      sb.push_back(e);
      bus2.read  = rd;
      bus2.wren  = wr;
      bus2.addr  = a;
      bus2.wdata = d;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bus2.done === 1'b1 && lat == 0) lat = i;
         if (chg && i == 1) begin
            bus2.addr  = 9'h020;
            bus2.wdata = 32'h22;
         end
         if (i == hold) begin
            chk("busy_req", 32'(bus2.busy), 32'd1);
            bus2.read = 1'b0;
            bus2.wren = 1'b0;
         end
         if (lat != 0 && i >= hold) break;
      end
      chk("latency", 32'(lat), 32'd3);
      @(negedge clk);
      chk("busy_idle", 32'(bus2.busy), 32'd0);
      chk("done_count", 32'(n_done - d0), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n    = 1'b0;
      bus2.read  = 1'b0;
      bus2.wren  = 1'b0;
      bus2.addr  = '0;
      bus2.wdata = '0;
      bus0.read  = 1'b0;
      bus0.wren  = 1'b0;
      bus0.addr  = '0;
      bus0.wdata = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      // idle after reset
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("rst_rdata", bus2.rdata, 32'h0);
         chk("rst_done", 32'(bus2.done), 32'd0);
         chk("rst_busy", 32'(bus2.busy), 32'd0);
         chk("rst_err", 32'(bus2.err), 32'd0);
      end

      // write then read back
      issue(1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 1, 1'b0);
      issue(1'b1, 1'b0, 9'h005, 32'h0, 1, 1'b0);

      // held read level: single done, busy until the level drops
      issue(1'b1, 1'b0, 9'h005, 32'h0, 8, 1'b0);

      // bus changes during WAIT are ignored
      issue(1'b0, 1'b1, 9'h020, 32'h55, 1, 1'b0);
      issue(1'b0, 1'b1, 9'h010, 32'h11, 2, 1'b1);
      issue(1'b1, 1'b0, 9'h010, 32'h0, 1, 1'b0);
      issue(1'b1, 1'b0, 9'h020, 32'h0, 1, 1'b0);

      // read/write conflict executes as a write and flags err
      issue(1'b1, 1'b1, 9'h007, 32'h1234, 1, 1'b0);
      issue(1'b1, 1'b0, 9'h007, 32'h0, 1, 1'b0);

      // reset during the wait of a write discards it
      issue(1'b0, 1'b1, 9'h003, 32'h0, 1, 1'b0);
      bus2.wren  = 1'b1;
      bus2.addr  = 9'h003;
      bus2.wdata = 32'hFFFF;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_busy", 32'(bus2.busy), 32'd0);
      bus2.wren = 1'b0;
      last_rd   = 32'h0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      issue(1'b1, 1'b0, 9'h003, 32'h0, 1, 1'b0);
      issue(1'b1, 1'b0, 9'h007, 32'h0, 1, 1'b0);

      // zero wait states: done in the cycle right after acceptance
      bus0.wren  = 1'b1;
      bus0.addr  = 9'h001;
      bus0.wdata = 32'hA5A5_0001;
      @(negedge clk);
      chk("w0_done", 32'(bus0.done), 32'd1);
      bus0.wren = 1'b0;
      @(negedge clk);
      chk("w0_done_off", 32'(bus0.done), 32'd0);
      chk("w0_busy_off", 32'(bus0.busy), 32'd0);
      bus0.read = 1'b1;
      @(negedge clk);
      chk("r0_done", 32'(bus0.done), 32'd1);
      chk("r0_rdata", bus0.rdata, 32'hA5A5_0001);
      chk("r0_err", 32'(bus0.err), 32'd0);
      bus0.read = 1'b0;
      @(negedge clk);
      chk("r0_busy_off", 32'(bus0.busy), 32'd0);

      chk("sb_left", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Single-port word memory responder that services the CPU control unit's `read`/`wren` requests, addressed by MAR and written from MDR. It sits between the datapath's MAR/MDR registers and the storage array. It inserts a configurable number of wait states and signals completion with a one-cycle `done` pulse, so the control unit can hold its memory state until the access finishes.

## Interface
- `ADDR_W`, default 9: address width; the array depth is 2^ADDR_W words.
- `WORD_W`, default 32: data word width.
- `WAIT_CYCLES`, default 2: wait states inserted before completion. Legal range is 0..15.

- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `read` input, 1 bit: read request (level), driven by the control unit.
- `wren` input, 1 bit: write request (level), driven by the control unit.
- `addr` input, ADDR_W bits: word address, taken from the MAR output.
- `wdata` input, WORD_W bits: write data, taken from the MDR output.
- `rdata` output, WORD_W bits: registered read data, feeds the MDR input mux.
- `done` output, 1 bit: one-cycle completion pulse.
- `busy` output, 1 bit: high from request acceptance until return to IDLE.
- `err` output, 1 bit: pulses together with `done` when `read` and `wren` were both high at acceptance.

## Operation
- **FSM states:** IDLE, WAIT, DONE, HOLD.
- **IDLE**
  - When (`read` | `wren`) is high at a rising edge, the request is accepted.
  - On acceptance the block latches `addr`, `wdata`, and the operation (op = write if `wren`, else read) and records the conflict flag.
  - Next state is WAIT with counter = WAIT_CYCLES−1, or DONE directly if WAIT_CYCLES = 0.
- **WAIT**
  - The counter decrements each cycle; the block moves to DONE on the edge where the counter equals 0.
  - Changes on `addr`, `wdata`, `read`, or `wren` during WAIT are ignored.
- **Entering DONE** (same edge as the transition):
  - A write commits the latched data to `array[latched addr]`.
  - A read loads `rdata` from `array[latched addr]`.
- **DONE**
  - `done` = 1 and `err` = conflict flag, for exactly this one cycle.
  - Next state is IDLE if `read` and `wren` are both low, otherwise HOLD.
- **HOLD**
  - The block waits until `read` and `wren` are both low, then returns to IDLE.
  - This prevents a request level that is still held from being accepted twice.
- **Conflict:** if `read` and `wren` are both high at acceptance, the access executes as a write and `err` is asserted with `done`.
- **`rdata`** holds its value until the next read completes. A write does not alter `rdata`.
- **Address range:** addresses are always in range, since depth is 2^ADDR_W. There is no wrap logic and no bounds check.
- **`busy`** = (state != IDLE).

## Timing
- **Reset values:** state = IDLE, `rdata` = 0, `done` = 0, `busy` = 0, `err` = 0, counter = 0.
- **Array contents are not reset.**
- **Reset mid-access:** an assertion of `reset_n` takes effect immediately and forces IDLE. A pending write that has not yet reached DONE is discarded and the array is unchanged.
- **Latency:** let E1 be the acceptance edge. `done` is high in the cycle following edge E1+WAIT_CYCLES.
  - With WAIT_CYCLES = 0, `done` is high in the cycle right after E1.
- **Read data validity:** `rdata` is valid from the `done` cycle onward. The control unit samples it into MDR during the `done` cycle.
- **Back-to-back accesses:** the minimum spacing is WAIT_CYCLES+2 cycles per access, requiring the requester to drop its request during the `done` cycle.
- **Read-after-write:** a read to the same address returns the newly written data; there is no bypass hazard because accesses are sequential.

## Structure
- **Shared package `cpu_pkg`** holds:
  - the state enum `mem_state_t` (IDLE, WAIT, DONE, HOLD);
  - `WORD_W` = 32;
  - the default `ADDR_W` = 9.
- **Sub-module `mem_array`:** synchronous single-port RAM with parameters ADDR_W and WORD_W, inputs `we`, `addr`, `wdata`, and a registered output `q`.
  - `mem_responder` contains the FSM, the wait counter, and the request latches.

## Test plan
- **Reset:** apply reset with `reset_n` = 0, release, then hold `read` = `wren` = 0 for 10 cycles → `rdata` = 0; `done`, `busy`, `err` stay 0; state = IDLE.
- **Write then read (WAIT_CYCLES = 2):**
  - Write 0xDEADBEEF to addr 0x05.
  - `done` is high in the cycle after E1+2.
  - Read addr 0x05 → `rdata` = 0xDEADBEEF in the `done` cycle, and `err` = 0.
- **Held request:** hold `read` high for 8 cycles at addr 0x05 → exactly one `done` pulse. `busy` stays high until `read` drops, then returns to 0 one cycle later.
- **Address change during WAIT:** change `addr` and `wdata` during WAIT (write 0x11 to 0x10, then drive addr 0x20 / data 0x22 mid-wait) → array[0x10] = 0x11 and array[0x20] is unchanged.
- **Conflict:** drive `read` = `wren` = 1 with addr 0x07 and data 0x1234 → `err` and `done` pulse together, and a later read of 0x07 returns 0x1234.
- **Reset mid-write, then WAIT_CYCLES = 0:**
  - Assert `reset_n` = 0 during WAIT of a write of 0xFFFF to 0x03 → a later read of 0x03 returns its prior value 0x0.
  - Rerun with WAIT_CYCLES = 0 → `done` is high in the cycle immediately after E1.
